// File: rtl/seq_det_pkg.sv
// Shared types and reset-default constants for the byte-stream pattern detector.
package seq_det_pkg;

  localparam int PAT_MAX_DEF = 8;
  localparam int LEN_W = 4;
  localparam logic [7:0] DEF_PATTERN = 8'b0000_1010;
  localparam logic [LEN_W-1:0] DEF_LEN = 4'd4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    REPORT
  } state_t;

  function automatic logic len_legal(input logic [LEN_W-1:0] len, input int pat_max);
    return (len != '0) && (int'(len) <= pat_max);
  endfunction

endpackage

// File: rtl/seq_det_core.sv
// Bit-serial detector: history shift register, fill counter and length-masked compare.
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter int PAT_MAX = PAT_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               bit_valid,
  input  logic               bit_in,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               match
);

  localparam int FILL_W = $clog2(PAT_MAX + 1);

  logic [PAT_MAX-1:0] hist_reg;
  logic [PAT_MAX-1:0] hist_next;
  logic [FILL_W-1:0]  fill_reg;
  logic [FILL_W-1:0]  fill_next;
  logic [PAT_MAX-1:0] len_mask;
  logic               hit;

  // Only the newest len bits take part in the compare.
  for (genvar gi = 0; gi < PAT_MAX; gi++) begin : g_mask
    assign len_mask[gi] = (32'(len) > gi);
  end

  assign hist_next = {hist_reg[PAT_MAX-2:0], bit_in};
  assign fill_next = (fill_reg == FILL_W'(PAT_MAX)) ? fill_reg : fill_reg + FILL_W'(1);
  assign hit       = (32'(fill_next) >= 32'(len)) &&
                     (((hist_next ^ pattern) & len_mask) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_reg <= '0;
      fill_reg <= '0;
      match    <= 1'b0;
    end else if (clr) begin
      hist_reg <= '0;
      fill_reg <= '0;
      match    <= 1'b0;
    end else if (bit_valid) begin
      hist_reg <= hist_next;
      // Non-overlapping mode restarts the fill so the next hit needs len fresh bits.
      fill_reg <= (hit && !overlap) ? '0 : fill_next;
      match    <= hit;
    end else begin
      match    <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Byte-stream sequencing controller: accepts bytes, feeds them MSB-first to the detector core,
// and reports per-byte and running match counts.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               det_pulse,
  output logic               done,
  output logic [3:0]         byte_matches,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy
);

  state_t             state_reg;
  logic [7:0]         data_reg;
  logic [2:0]         idx_reg;
  logic [3:0]         byte_cnt_reg;
  logic [PAT_MAX-1:0] pattern_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               overlap_reg;
  logic               cfg_load;

  assign in_ready = (state_reg == IDLE) && !cfg_we;
  assign busy     = (state_reg != IDLE);
  assign cfg_load = cfg_we && (state_reg == IDLE) && len_legal(cfg_len, PAT_MAX);

  seq_det_core #(
    .PAT_MAX(PAT_MAX)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .clr      (cfg_load),
    .bit_valid(state_reg == SHIFT),
    .bit_in   (data_reg[idx_reg]),
    .pattern  (pattern_reg),
    .len      (len_reg),
    .overlap  (overlap_reg),
    .match    (det_pulse)
  );

  // det_pulse reflects the previous shift edge, so counters absorb it one edge later;
  // the final bit's match is folded in when the byte is reported.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      data_reg     <= '0;
      idx_reg      <= '0;
      byte_cnt_reg <= '0;
      pattern_reg  <= PAT_MAX'(DEF_PATTERN);
      len_reg      <= DEF_LEN;
      overlap_reg  <= 1'b1;
      cfg_err      <= 1'b0;
      done         <= 1'b0;
      byte_matches <= '0;
      match_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (det_pulse) begin
        byte_cnt_reg <= byte_cnt_reg + 4'd1;
        if (match_cnt != '1) begin
          match_cnt <= match_cnt + CNT_W'(1);
        end
      end
      case (state_reg)
        IDLE: begin
          if (cfg_we) begin
            if (cfg_load) begin
              pattern_reg <= cfg_pattern;
              len_reg     <= cfg_len;
              overlap_reg <= cfg_overlap;
              match_cnt   <= '0;
              cfg_err     <= 1'b0;
            end else begin
              cfg_err     <= 1'b1;
            end
          end else if (in_valid) begin
            data_reg     <= in_data;
            idx_reg      <= 3'd7;
            byte_cnt_reg <= '0;
            state_reg    <= SHIFT;
          end
        end
        SHIFT: begin
          idx_reg <= idx_reg - 3'd1;
          if (idx_reg == 3'd0) begin
            state_reg <= REPORT;
          end
        end
        REPORT: begin
          done         <= 1'b1;
          byte_matches <= byte_cnt_reg + {3'b000, det_pulse};
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
